execute_stage: RTL and testbench
================================

# execute_stage

Execute stage of the five-stage pipelined processor datapath. Captures decoded operands into the decode/execute pipeline register and computes the ALU result combinationally. Registers the result, store data and destination register into the execute/memory pipeline register. Sits between the register-file/decode logic and the data memory / write-back register.

## Interface
Parameters:
- WIDTH, 32, datapath width
- RW, 5, register-index width

Ports:
- clk  in  1  clock, rising-edge
- reset  in  1  asynchronous, active-high; clears all pipeline registers
- rd1  in  WIDTH  register-file read port 1 (source A)
- StoreDataD  in  WIDTH  decode-stage rs2 / store data (already byte-extended upstream)
- WriteRegD  in  RW  destination register index (instr[11:7])
- SignImmD  in  WIDTH  sign-extended immediate
- ALUSrcE  in  1  0 selects rd2E as ALU B operand, 1 selects SignImmE
- AluControlE  in  3  ALU operation
- SrcAE, rd2E, WriteDataE, SignImmE  out  WIDTH  decode/execute register contents
- WriteRegE  out  RW  decode/execute register contents
- aluresult  out  WIDTH  combinational ALU output
- ALUOutM, WriteDataM  out  WIDTH  execute/memory register contents
- WriteRegM  out  RW  execute/memory register contents

## Operation
- D/E register, loaded every rising edge with no enable or flush:
  - SrcAE←rd1
  - rd2E←StoreDataD
  - WriteDataE←StoreDataD
  - WriteRegE←WriteRegD
  - SignImmE←SignImmD
- SrcBE = ALUSrcE ? SignImmE : rd2E. SrcBE is internal.
- AluControlE encoding:
  - 000 AND
  - 001 OR
  - 010 ADD
  - 011 XOR
  - 100 SLL by SrcBE[4:0]
  - 101 SRL (logical) by SrcBE[4:0]
  - 110 SUB (A−B)
  - 111 SLT (signed; result 1 or 0, zero-extended)
- Arithmetic is modulo 2^WIDTH. Overflow is discarded and has no flag.
- Shift amounts use only SrcBE[4:0]; upper bits are ignored.
- E/M register, loaded every rising edge:
  - ALUOutM←aluresult
  - WriteDataM←WriteDataE
  - WriteRegM←WriteRegE

## Timing
- Reset value of every registered output is 0.
- While reset is asserted, aluresult = f(0,0) per AluControlE; with ALUSrcE either value, B is 0.
- D/E outputs change one rising edge after the decode inputs are presented.
- aluresult is combinational, valid in the same cycle as the D/E contents and AluControlE/ALUSrcE.
- M outputs appear 2 rising edges after the decode inputs. Total latency is 2 cycles with throughput 1 per cycle.
- Reset mid-stream clears both registers immediately (asynchronously). The first edge after deassertion loads normally.
- Control inputs (ALUSrcE, AluControlE) are assumed to be already aligned to the E stage by the controller. They are not registered here.

## Configuration
- EXEC_ZERO_EN, when defined:
  - adds output ZeroE (1 bit), combinational, high when aluresult == 0
  - adds registered ZeroM, reset 0, loaded alongside ALUOutM
- When undefined, neither port exists and behaviour is otherwise identical.

## Structure
- Shared package exec_pkg holds:
  - the ALU opcode localparams (ALU_AND…ALU_SLT) as a 3-bit typedef
  - the WIDTH/RW defaults
- One sub-module, exec_alu: purely combinational, with inputs A, B and op, and outputs result (and zero under EXEC_ZERO_EN).
- The B-operand mux and both pipeline registers live in the top.

## Test plan
1. Reset: assert reset mid-cycle with nonzero contents in both registers. All D/E and M outputs must drop to 0 immediately without a clock edge.
2. Add immediate:
   - Stimulus: rd1=5, SignImmD=0xFFFFFFFD (−3), WriteRegD=7, ALUSrcE=1, op=010.
   - After edge 1: SrcAE=5, SignImmE=−3, aluresult=2.
   - After edge 2: ALUOutM=2, WriteRegM=7.
3. Register ops:
   - Stimulus: rd1=0x0F0F, StoreDataD=0x00FF, ALUSrcE=0.
   - Required results: AND→0x000F, OR→0x0FFF, XOR→0x0FF0, SUB→0x0E10.
4. SLT signed:
   - A=0xFFFFFFFF, B=1 → 1.
   - A=1, B=0xFFFFFFFF → 0.
5. Shifts:
   - A=0x80000001, B=0x21: SLL → 0x00000002, SRL → 0x40000000. Only B[4:0]=1 is used.
6. Store path:
   - StoreDataD=0xDEADBEEF with ALUSrcE=1.
   - After 2 edges: WriteDataM=0xDEADBEEF, while ALUOutM holds the address sum.
   - With EXEC_ZERO_EN: SUB of equal operands gives ZeroE=1, and ZeroM=1 one edge later.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage: ALU opcode type/values and default widths.
package exec_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int RW_DEF    = 5;

    typedef logic [2:0] alu_op_t;

    localparam alu_op_t ALU_AND = 3'b000;
    localparam alu_op_t ALU_OR  = 3'b001;
    localparam alu_op_t ALU_ADD = 3'b010;
    localparam alu_op_t ALU_XOR = 3'b011;
    localparam alu_op_t ALU_SLL = 3'b100;
    localparam alu_op_t ALU_SRL = 3'b101;
    localparam alu_op_t ALU_SUB = 3'b110;
    localparam alu_op_t ALU_SLT = 3'b111;

endpackage

// File: rtl/execute_stage_if.sv
// Decode-side inputs, E-stage control and the D/E and E/M register outputs of the execute stage.
// Optional EXEC_ZERO_EN adds the ZeroE/ZeroM flags.
interface execute_stage_if
    import exec_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int RW    = RW_DEF
);
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] StoreDataD;
    logic [RW-1:0]    WriteRegD;
    logic [WIDTH-1:0] SignImmD;
    logic             ALUSrcE;
    alu_op_t          AluControlE;

    logic [WIDTH-1:0] SrcAE;
    logic [WIDTH-1:0] rd2E;
    logic [WIDTH-1:0] WriteDataE;
    logic [WIDTH-1:0] SignImmE;
    logic [RW-1:0]    WriteRegE;
    logic [WIDTH-1:0] aluresult;
    logic [WIDTH-1:0] ALUOutM;
    logic [WIDTH-1:0] WriteDataM;
    logic [RW-1:0]    WriteRegM;
`ifdef EXEC_ZERO_EN
    logic             ZeroE;
    logic             ZeroM;
`endif

    modport slave (
        input  rd1, StoreDataD, WriteRegD, SignImmD, ALUSrcE, AluControlE,
        output SrcAE, rd2E, WriteDataE, SignImmE, WriteRegE, aluresult,
`ifdef EXEC_ZERO_EN
        output ZeroE, ZeroM,
`endif
        output ALUOutM, WriteDataM, WriteRegM
    );

    modport master (
        output rd1, StoreDataD, WriteRegD, SignImmD, ALUSrcE, AluControlE,
        input  SrcAE, rd2E, WriteDataE, SignImmE, WriteRegE, aluresult,
`ifdef EXEC_ZERO_EN
        input  ZeroE, ZeroM,
`endif
        input  ALUOutM, WriteDataM, WriteRegM
    );

endinterface

// File: rtl/exec_alu.sv
// Combinational ALU for the execute stage; modulo-2^WIDTH arithmetic, shifts use B[4:0] only.
// With EXEC_ZERO_EN an extra zero output flags a zero result.
module exec_alu
    import exec_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  alu_op_t          op,
`ifdef EXEC_ZERO_EN
    output logic             zero,
`endif
    output logic [WIDTH-1:0] result
);

    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic                    lt;

    assign a_s = A;
    assign b_s = B;
    assign lt  = (a_s < b_s);

    always_comb begin
        result = '0;
        case (op)
            ALU_AND: result = A & B;
            ALU_OR:  result = A | B;
            ALU_ADD: result = A + B;
            ALU_XOR: result = A ^ B;
            ALU_SLL: result = A << B[4:0];
            ALU_SRL: result = A >> B[4:0];
            ALU_SUB: result = A - B;
            ALU_SLT: result = {{(WIDTH-1){1'b0}}, lt};
            default: result = '0;
        endcase
    end

`ifdef EXEC_ZERO_EN
    assign zero = (result == '0);
`endif

endmodule

// File: rtl/execute_stage.sv
// Execute stage: D/E pipeline register, B-operand mux, ALU and E/M pipeline register.
// Define EXEC_ZERO_EN to add the ZeroE/ZeroM flags.
module execute_stage
    import exec_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int RW    = RW_DEF
) (
    input logic           clk,
    input logic           reset,
    execute_stage_if.slave bus
);

    logic [WIDTH-1:0] src_a_p1, rd2_p1, wdata_p1, imm_p1;
    logic [RW-1:0]    wreg_p1;
    logic [WIDTH-1:0] alu_out_p2, wdata_p2;
    logic [RW-1:0]    wreg_p2;
    logic [WIDTH-1:0] src_b;
    logic [WIDTH-1:0] alu_res;

    // D/E boundary
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_a_p1 <= '0;
            rd2_p1   <= '0;
            wdata_p1 <= '0;
            imm_p1   <= '0;
            wreg_p1  <= '0;
        end else begin
            src_a_p1 <= bus.rd1;
            rd2_p1   <= bus.StoreDataD;
            wdata_p1 <= bus.StoreDataD;
            imm_p1   <= bus.SignImmD;
            wreg_p1  <= bus.WriteRegD;
        end
    end

    assign src_b = bus.ALUSrcE ? imm_p1 : rd2_p1;

`ifdef EXEC_ZERO_EN
    logic zero_e;
    logic zero_p2;

    exec_alu #(.WIDTH(WIDTH)) u_alu (
        .A      (src_a_p1),
        .B      (src_b),
        .op     (bus.AluControlE),
        .zero   (zero_e),
        .result (alu_res)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) zero_p2 <= 1'b0;
        else       zero_p2 <= zero_e;
    end

    assign bus.ZeroE = zero_e;
    assign bus.ZeroM = zero_p2;
`else
    exec_alu #(.WIDTH(WIDTH)) u_alu (
        .A      (src_a_p1),
        .B      (src_b),
        .op     (bus.AluControlE),
        .result (alu_res)
    );
`endif

    // E/M boundary
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_out_p2 <= '0;
            wdata_p2   <= '0;
            wreg_p2    <= '0;
        end else begin
            alu_out_p2 <= alu_res;
            wdata_p2   <= wdata_p1;
            wreg_p2    <= wreg_p1;
        end
    end

    assign bus.SrcAE      = src_a_p1;
    assign bus.rd2E       = rd2_p1;
    assign bus.WriteDataE = wdata_p1;
    assign bus.SignImmE   = imm_p1;
    assign bus.WriteRegE  = wreg_p1;
    assign bus.aluresult  = alu_res;
    assign bus.ALUOutM    = alu_out_p2;
    assign bus.WriteDataM = wdata_p2;
    assign bus.WriteRegM  = wreg_p2;

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed literal cases plus randomized traffic against a reference model.
module tb_execute_stage;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    execute_stage_if #(.WIDTH(32), .RW(5)) bus ();

    execute_stage #(.WIDTH(32), .RW(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference state: what each pipeline register must hold right now
    logic [31:0] m_a, m_rd2, m_wd, m_imm, m_out, m_wdm;
    logic [4:0]  m_wr, m_wrm;
    logic        m_zm;

    function automatic logic [31:0] alu_ref(logic [31:0] a, logic [31:0] b, logic [2:0] op);
        int          sh;
        int          sa;
        int          sb;
        longint unsigned wide;
        sh = int'(b[4:0]);
        sa = a;
        sb = b;
        case (op)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: begin wide = longint'(a) + longint'(b); return wide[31:0]; end
            3'd3: return a ^ b;
            3'd4: begin wide = longint'(a) * (64'd1 << sh); return wide[31:0]; end
            3'd5: return a / (32'd1 << sh);
            3'd6: begin wide = longint'(a) + (64'd1 << 32) - longint'(b); return wide[31:0]; end
            default: return (sa < sb) ? 32'd1 : 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] exp_alu();
        return alu_ref(m_a, bus.ALUSrcE ? m_imm : m_rd2, bus.AluControlE);
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h required %h at %0t", name, got, want, $time);
        end
    endtask

    task automatic model_clear();
        m_a = 0; m_rd2 = 0; m_wd = 0; m_imm = 0; m_wr = 0;
        m_out = 0; m_wdm = 0; m_wrm = 0; m_zm = 0;
    endtask

    task automatic model_edge();
        logic [31:0] r;
        r     = exp_alu();
        m_out = r;
        m_zm  = (r == 0);
        m_wdm = m_wd;
        m_wrm = m_wr;
        m_a   = bus.rd1;
        m_rd2 = bus.StoreDataD;
        m_wd  = bus.StoreDataD;
        m_imm = bus.SignImmD;
        m_wr  = bus.WriteRegD;
    endtask

    task automatic compare_all();
        check("SrcAE",      bus.SrcAE,            m_a);
        check("rd2E",       bus.rd2E,             m_rd2);
        check("WriteDataE", bus.WriteDataE,       m_wd);
        check("SignImmE",   bus.SignImmE,         m_imm);
        check("WriteRegE",  32'(bus.WriteRegE),   32'(m_wr));
        check("aluresult",  bus.aluresult,        exp_alu());
        check("ALUOutM",    bus.ALUOutM,          m_out);
        check("WriteDataM", bus.WriteDataM,       m_wdm);
        check("WriteRegM",  32'(bus.WriteRegM),   32'(m_wrm));
`ifdef EXEC_ZERO_EN
        check("ZeroE",      32'(bus.ZeroE),       32'(exp_alu() == 0));
        check("ZeroM",      32'(bus.ZeroM),       32'(m_zm));
`endif
    endtask

    task automatic step();
        @(posedge clk);
        if (!reset) model_edge();
        @(negedge clk);
        compare_all();
    endtask

    // Called at a negedge: pulses reset inside the low phase, no clock edge involved
    task automatic mid_reset();
        #2 reset = 1'b1;
        model_clear();
        #1 compare_all();
        check("rst_SrcAE_zero",   bus.SrcAE,   32'd0);
        check("rst_ALUOutM_zero", bus.ALUOutM, 32'd0);
        #1 reset = 1'b0;
    endtask

    task automatic drive(logic [31:0] a, logic [31:0] sd, logic [4:0] wr,
                         logic [31:0] imm, logic src, logic [2:0] op);
        bus.rd1 = a; bus.StoreDataD = sd; bus.WriteRegD = wr;
        bus.SignImmD = imm; bus.ALUSrcE = src; bus.AluControlE = op;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        model_clear();
        drive(32'h1234_5678, 32'h9ABC_DEF0, 5'd3, 32'h0000_0010, 1'b1, 3'b010);

        // Reset state, with nonzero inputs presented
        @(negedge clk);
        compare_all();
        check("reset_alu_f00", bus.aluresult, 32'd0);
        #2 reset = 1'b0;

        // Add immediate
        drive(32'd5, 32'd0, 5'd7, 32'hFFFF_FFFD, 1'b1, 3'b010);
        step();
        check("addi_SrcAE",    bus.SrcAE,     32'd5);
        check("addi_SignImmE", bus.SignImmE,  32'hFFFF_FFFD);
        check("addi_alu",      bus.aluresult, 32'd2);
        step();
        check("addi_ALUOutM",   bus.ALUOutM,         32'd2);
        check("addi_WriteRegM", 32'(bus.WriteRegM),  32'd7);

        // Register-register ops; control is combinational so op changes mid-cycle
        drive(32'h0F0F, 32'h00FF, 5'd1, 32'h0, 1'b0, 3'b000);
        step();
        check("reg_and", bus.aluresult, 32'h000F);
        bus.AluControlE = 3'b001; #1 check("reg_or",  bus.aluresult, 32'h0FFF); compare_all();
        bus.AluControlE = 3'b011; #1 check("reg_xor", bus.aluresult, 32'h0FF0); compare_all();
        bus.AluControlE = 3'b110; #1 check("reg_sub", bus.aluresult, 32'h0E10); compare_all();

        // Signed compare
        drive(32'hFFFF_FFFF, 32'h0, 5'd2, 32'd1, 1'b1, 3'b111);
        step();
        check("slt_neg_lt_pos", bus.aluresult, 32'd1);
        drive(32'd1, 32'h0, 5'd2, 32'hFFFF_FFFF, 1'b1, 3'b111);
        step();
        check("slt_pos_lt_neg", bus.aluresult, 32'd0);

        // Shifts use only B[4:0]
        drive(32'h8000_0001, 32'h0, 5'd4, 32'h21, 1'b1, 3'b100);
        step();
        check("sll_b21", bus.aluresult, 32'h0000_0002);
        bus.AluControlE = 3'b101; #1 check("srl_b21", bus.aluresult, 32'h4000_0000); compare_all();

        // Store path: data travels alongside the address sum
        drive(32'h0000_1000, 32'hDEAD_BEEF, 5'd9, 32'h20, 1'b1, 3'b010);
        step();
        step();
        check("store_WriteDataM", bus.WriteDataM, 32'hDEAD_BEEF);
        check("store_ALUOutM",    bus.ALUOutM,    32'h0000_1020);

`ifdef EXEC_ZERO_EN
        drive(32'h55, 32'h55, 5'd1, 32'h0, 1'b0, 3'b110);
        step();
        check("zeroE_sub_eq", 32'(bus.ZeroE), 32'd1);
        step();
        check("zeroM_sub_eq", 32'(bus.ZeroM), 32'd1);
`endif

        // Both registers hold nonzero data here; reset without a clock edge
        drive(32'hA5A5_0001, 32'h3C3C_0002, 5'd17, 32'h7, 1'b0, 3'b001);
        step();
        step();
        mid_reset();
        step();
        check("post_reset_load", bus.SrcAE, 32'hA5A5_0001);

        // Randomized traffic with occasional asynchronous resets
        for (int i = 0; i < 400; i++) begin
            drive($urandom, $urandom, 5'($urandom), $urandom,
                  1'($urandom), 3'($urandom));
            if ($urandom_range(0, 7) == 0) bus.SignImmD = 32'($urandom_range(0, 70));
            if ($urandom_range(0, 9) == 0) bus.StoreDataD = bus.rd1;
            if ($urandom_range(0, 39) == 0) mid_reset();
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
